// File: rtl/can_bit_sampler.sv
// CAN receive bit sampler: input synchroniser, tq-based bit timing with hard sync
// and SJW-limited resync, single sample per bit, destuffing and bus-idle detect.
module can_bit_sampler #(
  parameter int unsigned BRP   = 4,
  parameter int unsigned TSEG1 = 7,
  parameter int unsigned TSEG2 = 2,
  parameter int unsigned SJW   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic can_rx,
  output logic sample_strobe,
  output logic bit_valid,
  output logic bit_data,
  output logic stuff_err,
  output logic bus_idle
);

  localparam int unsigned PW = (BRP > 1) ? $clog2(BRP) : 1;
  localparam int unsigned TW = $clog2(TSEG1 + SJW + TSEG2 + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(BRP - 1);
  localparam logic [TW-1:0] T1_LEN    = TW'(TSEG1);
  localparam logic [TW-1:0] T2_LEN    = TW'(TSEG2);
  localparam logic [TW-1:0] SJW_LEN   = TW'(SJW);
  localparam logic [3:0]    IDLE_LAST = 4'd10;

  typedef enum logic [1:0] {
    SEG_SYNC,
    SEG_TSEG1,
    SEG_TSEG2
  } seg_t;

  logic          sync_q;
  logic          rx_s;
  logic          rx_s_d;
  logic [PW-1:0] presc;
  logic [TW-1:0] tq_cnt;
  logic [TW-1:0] len1;
  logic [TW-1:0] len2;
  seg_t          seg;
  logic          resync_done;
  logic          err_wait;
  logic [2:0]    run_cnt;
  logic          run_val;
  logic [3:0]    idle_cnt;

  logic          edge_det;
  logic          tick;
  logic          hard_sync;
  logic          resync;
  logic          strobe_now;
  logic          end_tseg2;
  logic [TW-1:0] len1_n;
  logic [TW-1:0] len2_n;
  logic [TW-1:0] rem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else if (!enable) begin
      sync_q <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= can_rx;
      rx_s   <= sync_q;
      rx_s_d <= rx_s;
    end
  end

  assign edge_det      = rx_s_d & ~rx_s;
  assign tick          = (presc == PRESC_MAX);
  assign hard_sync     = edge_det & (bus_idle | err_wait);
  assign resync        = edge_det & ~hard_sync & ~resync_done & (seg != SEG_SYNC);
  assign strobe_now    = (seg == SEG_TSEG1) && tick && ((tq_cnt + TW'(1)) == len1);
  assign sample_strobe = strobe_now;

  // Segment lengths after this cycle's resync; an edge on the strobe clock is
  // handled as TSEG2 shortening when TSEG2 is entered, not as a TSEG1 extension.
  always_comb begin
    len1_n    = len1;
    len2_n    = len2;
    rem       = '0;
    if (resync && (seg == SEG_TSEG1) && !strobe_now) begin
      len1_n = len1 + ((tq_cnt < SJW_LEN) ? tq_cnt : SJW_LEN);
    end
    if (resync && (seg == SEG_TSEG2)) begin
      rem    = len2 - tq_cnt;
      len2_n = len2 - ((rem < SJW_LEN) ? rem : SJW_LEN);
    end
    end_tseg2 = (seg == SEG_TSEG2) &&
                ((tq_cnt >= len2_n) || (tick && ((tq_cnt + TW'(1)) >= len2_n)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      tq_cnt      <= '0;
      len1        <= T1_LEN;
      len2        <= T2_LEN;
      seg         <= SEG_SYNC;
      resync_done <= 1'b0;
      err_wait    <= 1'b0;
      run_cnt     <= '0;
      run_val     <= 1'b1;
      idle_cnt    <= '0;
      bus_idle    <= 1'b1;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b1;
      stuff_err   <= 1'b0;
    end else if (!enable) begin
      presc       <= '0;
      tq_cnt      <= '0;
      len1        <= T1_LEN;
      len2        <= T2_LEN;
      seg         <= SEG_SYNC;
      resync_done <= 1'b0;
      err_wait    <= 1'b0;
      run_cnt     <= '0;
      run_val     <= 1'b1;
      idle_cnt    <= '0;
      bus_idle    <= 1'b1;
      bit_valid   <= 1'b0;
      bit_data    <= 1'b1;
      stuff_err   <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      stuff_err <= 1'b0;

      if (hard_sync) begin
        presc       <= '0;
        tq_cnt      <= '0;
        len1        <= T1_LEN;
        len2        <= T2_LEN;
        seg         <= SEG_TSEG1;
        resync_done <= 1'b1;
        err_wait    <= 1'b0;
        run_cnt     <= '0;
        idle_cnt    <= '0;
        bus_idle    <= 1'b0;
      end else begin
        if (resync) begin
          resync_done <= 1'b1;
        end
        len1  <= len1_n;
        len2  <= len2_n;
        presc <= tick ? '0 : presc + PW'(1);

        case (seg)
          SEG_SYNC: begin
            if (tick) begin
              seg    <= SEG_TSEG1;
              tq_cnt <= '0;
            end
          end
          SEG_TSEG1: begin
            if (strobe_now) begin
              seg    <= SEG_TSEG2;
              tq_cnt <= '0;
              len2   <= resync ? (T2_LEN - SJW_LEN) : T2_LEN;
            end else if (tick) begin
              tq_cnt <= tq_cnt + TW'(1);
            end
          end
          SEG_TSEG2: begin
            if (end_tseg2) begin
              seg         <= SEG_SYNC;
              tq_cnt      <= '0;
              presc       <= '0;
              len1        <= T1_LEN;
              len2        <= T2_LEN;
              resync_done <= 1'b0;
            end else if (tick) begin
              tq_cnt <= tq_cnt + TW'(1);
            end
          end
          default: seg <= SEG_SYNC;
        endcase

        if (strobe_now) begin
          if (rx_s) begin
            if (idle_cnt == IDLE_LAST) begin
              bus_idle <= 1'b1;
            end
            if (idle_cnt <= IDLE_LAST) begin
              idle_cnt <= idle_cnt + 4'd1;
            end
          end else begin
            idle_cnt <= '0;
          end

          // Destuffing; a cleared run counter marks the SOF bit after hard sync.
          if (!bus_idle && !err_wait) begin
            if (run_cnt == 3'd5) begin
              if (rx_s != run_val) begin
                run_cnt <= 3'd1;
                run_val <= rx_s;
              end else begin
                stuff_err <= 1'b1;
                err_wait  <= 1'b1;
              end
            end else begin
              bit_valid <= 1'b1;
              bit_data  <= rx_s;
              if ((run_cnt != 3'd0) && (rx_s == run_val)) begin
                run_cnt <= run_cnt + 3'd1;
              end else begin
                run_cnt <= 3'd1;
                run_val <= rx_s;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_bit_sampler.sv
// Directed bench for can_bit_sampler: idle, hard sync, destuffing, stuff error,
// resync extension/shortening, mid-bit reset and enable hold.
module tb_can_bit_sampler;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b1;
  logic can_rx = 1'b1;
  logic sample_strobe;
  logic bit_valid;
  logic bit_data;
  logic stuff_err;
  logic bus_idle;

  can_bit_sampler #(.BRP(4), .TSEG1(7), .TSEG2(2), .SJW(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .can_rx        (can_rx),
    .sample_strobe (sample_strobe),
    .bit_valid     (bit_valid),
    .bit_data      (bit_data),
    .stuff_err     (stuff_err),
    .bus_idle      (bus_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int strobe_q[$];
  int bv_cyc[$];
  int bv_dat[$];
  int se_q[$];
  int T;
  int E;
  int R;

  always @(negedge clk) begin
    if (sample_strobe === 1'b1) strobe_q.push_back(cyc);
    if (bit_valid === 1'b1) begin
      bv_cyc.push_back(cyc);
      bv_dat.push_back(int'(bit_data));
    end
    if (stuff_err === 1'b1) se_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int x);
    while (cyc < T + x) tick(1);
  endtask

  task automatic clear_q();
    strobe_q.delete();
    bv_cyc.delete();
    bv_dat.delete();
    se_q.delete();
  endtask

  task automatic do_reset();
    can_rx = 1'b1;
    reset  = 1'b0;
    tick(2);
    reset  = 1'b1;
  endtask

  // Align to just after a free-running strobe, then start a frame with SOF.
  task automatic start_frame();
    int found;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (sample_strobe === 1'b1) begin
        found = 1;
        break;
      end
    end
    check("wait_strobe", found, 1);
    tick(1);
    clear_q();
    T = cyc;
    E = T + 2;
    can_rx = 1'b0;
  endtask

  initial begin
    // Test 1: long reset with recessive bus, then free-running idle sampling
    reset = 1'b0;
    tick(440);
    check("rst_bus_idle", bus_idle, 1);
    check("rst_strobe", sample_strobe, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_data", bit_data, 1);
    check("rst_stuff_err", stuff_err, 0);
    reset = 1'b1;
    R = cyc;
    clear_q();
    tick(500);
    check("idle_first_strobe", qat(strobe_q, 0), R + 31);
    check("idle_strobe_period", qat(strobe_q, 1) - qat(strobe_q, 0), 40);
    check("idle_strobe_count", strobe_q.size(), 12);
    check("idle_no_bit_valid", bv_cyc.size(), 0);
    check("idle_bus_idle", bus_idle, 1);

    // Tests 2/3: hard sync on SOF, four zeros, stuff 1, then a data 1
    start_frame();
    at(30);
    check("hs_bus_idle_clr", bus_idle, 0);
    at(200);
    can_rx = 1'b1;
    at(300);
    check("hs_strobe", qat(strobe_q, 0), E + 28);
    check("hs_next_strobe", qat(strobe_q, 1), E + 68);
    check("sof_valid_cyc", qat(bv_cyc, 0), E + 29);
    check("sof_data", qat(bv_dat, 0), 0);
    check("destuff_count", bv_cyc.size(), 6);
    check("destuff_bit4", qat(bv_dat, 4), 0);
    check("destuff_after_stuff", qat(bv_dat, 5), 1);
    check("destuff_after_cyc", qat(bv_cyc, 5), E + 269);
    check("destuff_no_err", se_q.size(), 0);
    do_reset();

    // Test 4: six dominant bits -> stuff error, then 11 recessive -> idle
    start_frame();
    at(240);
    can_rx = 1'b1;
    at(660);
    check("err_not_idle_yet", bus_idle, 0);
    at(680);
    check("err_idle_set", bus_idle, 1);
    check("err_count", se_q.size(), 1);
    check("err_cyc", qat(se_q, 0), E + 229);
    check("err_valid_count", bv_cyc.size(), 5);
    check("err_last_valid_cyc", qat(bv_cyc, 4), E + 189);
    do_reset();

    // Test 5: late edge extends TSEG1, second edge ignored, early edge shortens TSEG2
    start_frame();
    at(40);  can_rx = 1'b1;
    at(88);  can_rx = 1'b0;
    at(90);  can_rx = 1'b1;
    at(96);  can_rx = 1'b0;
    at(164); can_rx = 1'b1;
    at(196); can_rx = 1'b0;
    at(260);
    check("rs_strobe1", qat(strobe_q, 1), E + 68);
    check("rs_extend", qat(strobe_q, 2), E + 112);
    check("rs_second_edge", qat(strobe_q, 3), E + 152);
    check("rs_strobe4", qat(strobe_q, 4), E + 192);
    check("rs_shorten", qat(strobe_q, 5), E + 228);
    check("rs_valid_count", bv_dat.size(), 6);
    check("rs_bits", (qat(bv_dat, 0) << 5) | (qat(bv_dat, 1) << 4) | (qat(bv_dat, 2) << 3) |
                     (qat(bv_dat, 3) << 2) | (qat(bv_dat, 4) << 1) | qat(bv_dat, 5), 32'b010010);

    // Test 6: reset 20 clk into a bit aborts at once; hard sync needed afterwards
    do_reset();
    start_frame();
    at(40);  can_rx = 1'b1;
    at(62);
    check("mid_pre_bit_data", bit_data, 0);
    check("mid_pre_bus_idle", bus_idle, 0);
    clear_q();
    reset = 1'b0;
    #1;
    check("mid_rst_bus_idle", bus_idle, 1);
    check("mid_rst_bit_data", bit_data, 1);
    check("mid_rst_strobe", sample_strobe, 0);
    check("mid_rst_valid", bit_valid, 0);
    check("mid_rst_err", stuff_err, 0);
    tick(3);
    reset = 1'b1;
    tick(200);
    check("mid_no_valid", bv_cyc.size(), 0);
    T = cyc;
    E = T + 2;
    can_rx = 1'b0;
    at(40);
    check("mid_resync_count", bv_cyc.size(), 1);
    check("mid_resync_cyc", qat(bv_cyc, 0), E + 29);
    check("mid_resync_data", qat(bv_dat, 0), 0);

    // Enable low holds the block at reset values
    enable = 1'b0;
    tick(1);
    check("en_bus_idle", bus_idle, 1);
    check("en_bit_data", bit_data, 1);
    clear_q();
    tick(100);
    check("en_no_strobe", strobe_q.size(), 0);
    enable = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
